vga_user_event_ctrl: RTL and testbench
======================================

# vga_user_event_ctrl

Change-capture controller for the 22-bit VGA user input bus. It sits between the raw `in_port` lines and the HPS lightweight Avalon-MM bridge. It synchronizes the input and detects every value change. Each change is queued with an optional timestamp in a small FIFO, so software can drain events and take an interrupt instead of polling a plain input register.

## Interface
Parameters:
- `DATA_W`, 22, width of `in_port`; must be ≤ 22.
- `FIFO_DEPTH`, 8, event FIFO entries; power of two, 2–64.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `address`  in  2  Avalon-MM word address.
- `chipselect`  in  1  slave select; `read`/`write` are ignored when it is low.
- `read`  in  1  read strobe, single cycle.
- `write`  in  1  write strobe, single cycle.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `in_port`  in  DATA_W  asynchronous user input bus.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Input path: two-flop synchronizer (`sync1`, `sync2`) feeds `prev`. `prev` updates every cycle. A change is `sync2 != prev`.
- Change handling: a change with `capture_en=1` pushes `{ts, zero-pad, sync2}` into the FIFO.
- Disabled capture: `prev` keeps tracking while `capture_en=0`, so enabling capture never creates a spurious event.
- Register map:
  - addr 0 DATA (RO): `sync2` zero-extended.
  - addr 1 EVENT (RO, pops): head entry. If the FIFO is non-empty, a read pops it. If empty, the read returns 0 and nothing changes.
  - addr 2 CONTROL (RW):
    - bit0 `capture_en`.
    - bit1 `irq_en`.
    - bit2 `flush`: write-only and self-clearing; reads as 0.
  - addr 3 STATUS (RO except bit8):
    - bits[6:0] `count`.
    - bit7 `empty`.
    - bit8 `overflow`, sticky; writing 1 clears it.
    - other bits read 0.
- Full FIFO: a push is dropped, the FIFO contents are unchanged, and `overflow` is set.
- Push and pop in the same cycle:
  - When full: the pop frees a slot, the push is accepted, `overflow` is not set, and `count` stays at FIFO_DEPTH.
  - When empty: the read returns 0, and the push lands with `count`=1.
- Flush: clears the read/write pointers and `count`. A push in the same cycle is discarded, and `overflow` is not set by it.
- Overflow set and clear in the same cycle: set wins.
- `irq = irq_en & (!empty | overflow)`, driven from registered state only.
- Pointers wrap modulo FIFO_DEPTH. `count` is log2(FIFO_DEPTH)+1 bits wide, reaching 0..FIFO_DEPTH.

## Timing
- Reset values (a synchronous `reset_n=0` at any edge, including mid-transfer, applies all of these):
  - `readdata` = 0, `irq` = 0.
  - `sync1`, `sync2`, `prev` = 0.
  - FIFO empty.
  - `capture_en` = 0, `irq_en` = 0, `overflow` = 0.
  - timestamp counter = 0.
- Read latency is 1. `readdata` is valid the cycle after `read`, and holds until the next read.
- Write latency: a write takes effect at the edge where `write` is sampled.
- Change-to-event latency: `in_port` changes before edge k. `sync1` captures it at k, `sync2` at k+1, and the push happens at k+2. A STATUS read issued after k+2 shows the new `count`, and `irq` rises after k+2.
- Throughput: one push and one pop per cycle at most. Back-to-back changes on consecutive cycles each produce an event.

## Configuration
- `VGA_EVENT_TIMESTAMP_EN` defined:
  - A free-running 10-bit cycle counter (wraps 1023→0) runs from reset.
  - EVENT bits[31:22] hold the counter value at the push edge.
- `VGA_EVENT_TIMESTAMP_EN` undefined:
  - No counter is built.
  - EVENT bits[31:22] read 0.
  - FIFO storage is DATA_W bits wide.

## Test plan
- Reset, then read all four addresses → DATA = synchronized input, EVENT = 0, CONTROL = 0, STATUS = 0x80, `irq` = 0.
- Write CONTROL = 0x3, then drive `in_port` 0x000000 → 0x15A5A5 → STATUS `count`=1 three edges after the change and `irq`=1. EVENT read returns 0x15A5A5 in bits[21:0]; afterwards STATUS = 0x80 and `irq`=0.
- Produce 9 changes with depth 8 and no reads → `count`=8, `overflow`=1, and the first 8 values drain in order. Writing STATUS 0x100 clears `overflow`, and `irq` drops once the FIFO is empty.
- With the FIFO full, issue an EVENT read in the same cycle as a new change → no overflow, `count` stays 8, and the newest value appears as the last of 8 drained entries.
- Fill 3 entries, then write CONTROL = 0x7 on the same cycle as a change → `count`=0, `overflow`=0, and CONTROL reads back 0x3.
- With `VGA_EVENT_TIMESTAMP_EN` defined, make two changes 5 cycles apart → bits[31:22] differ by exactly 5, including across the 1023→0 wrap (mod 1024). Assert `reset_n`=0 mid-sequence → all state returns to its reset values on the next edge.

Source files
------------

// File: rtl/vga_user_event_ctrl.sv
// Change-capture controller for the VGA user input bus: synchronizes in_port, queues every
// value change in an event FIFO and exposes it over Avalon-MM. Optional build macro
// VGA_EVENT_TIMESTAMP_EN adds a 10-bit cycle timestamp in EVENT bits[31:22].
module vga_user_event_ctrl #(
    parameter int DATA_W     = 22,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
`ifdef VGA_EVENT_TIMESTAMP_EN
    localparam int EW = DATA_W + 10;
`else
    localparam int EW = DATA_W;
`endif

    logic [DATA_W-1:0] sync1;
    logic [DATA_W-1:0] sync2;
    logic [DATA_W-1:0] prev;
    logic              capture_en;
    logic              irq_en;
    logic              overflow;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     push_entry;

    logic        sel_rd;
    logic        sel_wr;
    logic        empty;
    logic        full;
    logic        do_flush;
    logic        wr_ctrl;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        ovf_set;
    logic        ovf_clr;
    logic [31:0] event_word;
    logic [31:0] status_word;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^{writedata[31:9], writedata[7:3]};

    always_comb begin
        sel_rd   = chipselect && read;
        sel_wr   = chipselect && write;
        empty    = (count == '0);
        full     = (count == FULL_COUNT);
        wr_ctrl  = sel_wr && (address == 2'd2);
        do_flush = wr_ctrl && writedata[2];
        pop      = sel_rd && (address == 2'd1) && !empty;
        push_req = capture_en && (sync2 != prev);
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
        push     = push_req && !do_flush && (!full || pop);
        ovf_set  = push_req && !do_flush && full && !pop;
        ovf_clr  = sel_wr && (address == 2'd3) && writedata[8];
    end

`ifdef VGA_EVENT_TIMESTAMP_EN
    logic [9:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 10'd1;
        end
    end

    assign push_entry = {ts_cnt, sync2};
`else
    assign push_entry = sync2;
`endif

    always_comb begin
        event_word = '0;
        if (!empty) begin
            event_word[DATA_W-1:0] = mem[rd_ptr][DATA_W-1:0];
`ifdef VGA_EVENT_TIMESTAMP_EN
            event_word[31:22] = mem[rd_ptr][EW-1:DATA_W];
`endif
        end
    end

    always_comb begin
        status_word         = '0;
        status_word[CW-1:0] = count;
        status_word[7]      = empty;
        status_word[8]      = overflow;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[DATA_W-1:0] = sync2;
            2'd1:    rd_mux = event_word;
            2'd2:    rd_mux[1:0] = {irq_en, capture_en};
            default: rd_mux = status_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (sel_rd) begin
            readdata <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            capture_en <= 1'b0;
            irq_en     <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            // prev tracks regardless of capture_en so enabling never sees a stale value.
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
            if (wr_ctrl) begin
                capture_en <= writedata[0];
                irq_en     <= writedata[1];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign irq = irq_en && (!empty || overflow);

endmodule

// File: tb/tb_vga_user_event_ctrl.sv
// Self-checking bench for vga_user_event_ctrl: randomized input changes checked against
// a queue-level model of the event FIFO, its status bits and the interrupt.
module tb_vga_user_event_ctrl;

    localparam int DW = 22;
    localparam int D  = 8;
`ifdef VGA_EVENT_TIMESTAMP_EN
    localparam logic [31:0] EV_MASK = 32'h003F_FFFF;
`else
    localparam logic [31:0] EV_MASK = 32'hFFFF_FFFF;
`endif

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port;
    logic          irq;

    int n_tests;
    int n_fail;
    int cyc;

    logic [DW-1:0] exp_q[$];
    logic          m_ovf;
    logic          m_cap;
    logic          m_irqen;
    logic [DW-1:0] last_in;

    vga_user_event_ctrl #(.DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks: each starts and ends 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    function automatic logic [DW-1:0] new_val();
        logic [DW-1:0] v;
        v = DW'($urandom);
        while (v == last_in) v = DW'($urandom);
        return v;
    endfunction

    // model: an input change becomes an event if capture is on and there is room
    task automatic change(input logic [DW-1:0] v);
        in_port = v;
        last_in = v;
        if (m_cap) begin
            if (exp_q.size() < D) exp_q.push_back(v);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[6:0] = 7'(exp_q.size());
        s[7]   = (exp_q.size() == 0);
        s[8]   = m_ovf;
        return s;
    endfunction

    function automatic logic exp_irq();
        return m_irqen && ((exp_q.size() != 0) || m_ovf);
    endfunction

    function automatic logic [31:0] exp_event();
        if (exp_q.size() == 0) return 32'h0;
        return {10'b0, exp_q.pop_front()};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_cap   = 1'b0;
        m_irqen = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [DW-1:0] r0;
        r0 = DW'($urandom);
        reset_n = 1'b0;
        in_port = r0;
        last_in = r0;
        model_reset();
        idle(2);
        n_tests++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b readdata=%h, need irq=0 readdata=0", irq, readdata);
        end
        reset_n = 1'b1;
        idle(3);
        bus_read(2'd0, d);
        n_tests++;
        if (d !== {10'b0, r0}) begin
            n_fail++;
            $display("FAIL reset_data: got %h need %h", d, {10'b0, r0});
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_event: got %h need 0", d);
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_control: got %h need 0", d);
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h80 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %h irq=%b need 80 irq=0", d, irq);
        end
    endtask

    task automatic test_single_event();
        logic [31:0] d;
        logic [31:0] e;
        change('0);
        idle(3);
        bus_write(2'd2, 32'h3);
        m_cap   = 1'b1;
        m_irqen = 1'b1;
        change(22'h15A5A5);
        idle(2);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL single_irq_early: got %b need 0", irq);
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h80 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: status %h irq %b need 80 irq 1", d, irq);
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status()) begin
            n_fail++;
            $display("FAIL single_count: got %h need %h", d, exp_status());
        end
        bus_read(2'd1, d);
        e = exp_event();
        n_tests++;
        if ((d & EV_MASK) !== e || e !== 32'h0015A5A5) begin
            n_fail++;
            $display("FAIL single_event: got %h need %h", d, e);
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h80 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drained: status %h irq %b need 80 irq 0", d, irq);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] e;
        for (int i = 0; i < 9; i++) begin
            change(new_val());
            idle(1);
        end
        idle(3);
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status() || d !== 32'h108 || irq !== exp_irq()) begin
            n_fail++;
            $display("FAIL ovf_status: got %h irq %b need %h irq %b", d, irq, exp_status(), exp_irq());
        end
        for (int i = 0; i < D; i++) begin
            bus_read(2'd1, d);
            e = exp_event();
            n_tests++;
            if ((d & EV_MASK) !== e) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got %h need %h", i, d, e);
            end
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h180 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %h irq %b need 180 irq 1", d, irq);
        end
        bus_write(2'd3, 32'h100);
        m_ovf = 1'b0;
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status() || irq !== exp_irq()) begin
            n_fail++;
            $display("FAIL ovf_clear: got %h irq %b need %h irq %b", d, irq, exp_status(), exp_irq());
        end
    endtask

    task automatic test_back_to_back_full_pop();
        logic [31:0] d;
        logic [31:0] e;
        logic [DW-1:0] v;
        for (int i = 0; i < D; i++) begin
            change(new_val());
            idle(1);
        end
        idle(3);
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status()) begin
            n_fail++;
            $display("FAIL b2b_fill: got %h need %h", d, exp_status());
        end
        v = new_val();
        in_port = v;
        last_in = v;
        idle(2);
        bus_read(2'd1, d);
        e = exp_event();
        exp_q.push_back(v);
        n_tests++;
        if ((d & EV_MASK) !== e) begin
            n_fail++;
            $display("FAIL fullpop_head: got %h need %h", d, e);
        end
        idle(1);
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status() || d !== 32'h008) begin
            n_fail++;
            $display("FAIL fullpop_status: got %h need %h", d, exp_status());
        end
        for (int i = 0; i < D; i++) begin
            bus_read(2'd1, d);
            e = exp_event();
            n_tests++;
            if ((d & EV_MASK) !== e) begin
                n_fail++;
                $display("FAIL fullpop_drain[%0d]: got %h need %h", i, d, e);
            end
        end
    endtask

    task automatic test_empty_pop_push();
        logic [31:0] d;
        logic [31:0] e;
        logic [DW-1:0] v;
        v = new_val();
        in_port = v;
        last_in = v;
        idle(2);
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL emptypop_read: got %h need 0", d);
        end
        exp_q.push_back(v);
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status() || d !== 32'h1) begin
            n_fail++;
            $display("FAIL emptypop_count: got %h need %h", d, exp_status());
        end
        bus_read(2'd1, d);
        e = exp_event();
        n_tests++;
        if ((d & EV_MASK) !== e) begin
            n_fail++;
            $display("FAIL emptypop_event: got %h need %h", d, e);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < ((pass == 0) ? 3 : D); i++) begin
                change(new_val());
                idle(1);
            end
            idle(3);
            bus_read(2'd3, d);
            n_tests++;
            if (d !== exp_status()) begin
                n_fail++;
                $display("FAIL flush_fill%0d: got %h need %h", pass, d, exp_status());
            end
            last_in = new_val();
            in_port = last_in;
            idle(2);
            bus_write(2'd2, 32'h7);
            exp_q.delete();
            idle(1);
            bus_read(2'd3, d);
            n_tests++;
            if (d !== exp_status() || d !== 32'h80 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_status%0d: got %h irq %b need 80 irq 0", pass, d, irq);
            end
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'h3) begin
            n_fail++;
            $display("FAIL flush_control: got %h need 3", d);
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_event: got %h need 0", d);
        end
    endtask

    task automatic test_disabled();
        logic [31:0] d;
        logic [31:0] e;
        bus_write(2'd2, 32'h2);
        m_cap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            change(new_val());
            idle(1);
        end
        idle(3);
        bus_read(2'd0, d);
        n_tests++;
        if (d !== {10'b0, last_in}) begin
            n_fail++;
            $display("FAIL disabled_data: got %h need %h", d, {10'b0, last_in});
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h80) begin
            n_fail++;
            $display("FAIL disabled_nocapture: got %h need 80", d);
        end
        bus_write(2'd2, 32'h3);
        m_cap = 1'b1;
        idle(3);
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h80 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_spurious: got %h irq %b need 80 irq 0", d, irq);
        end
        change(new_val());
        idle(3);
        bus_read(2'd1, d);
        e = exp_event();
        n_tests++;
        if ((d & EV_MASK) !== e || e == 32'h0) begin
            n_fail++;
            $display("FAIL enabled_event: got %h need %h", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        int n;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                m_irqen = 1'($urandom_range(0, 1));
                bus_write(2'd2, {30'b0, m_irqen, 1'b1});
            end
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                change(new_val());
                idle($urandom_range(1, 2));
            end
            idle(3);
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                bus_read(2'd1, d);
                e = exp_event();
                n_tests++;
                if ((d & EV_MASK) !== e) begin
                    n_fail++;
                    $display("FAIL rand_event[%0d.%0d]: got %h need %h", r, i, d, e);
                end
            end
            bus_read(2'd3, d);
            n_tests++;
            if (d !== exp_status() || irq !== exp_irq()) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got %h irq %b need %h irq %b", r, d, irq, exp_status(), exp_irq());
            end
            if (m_ovf && $urandom_range(0, 1) == 1) begin
                bus_write(2'd3, 32'h100);
                m_ovf = 1'b0;
            end
        end
        bus_write(2'd3, 32'h100);
        m_ovf = 1'b0;
        while (exp_q.size() != 0) begin
            bus_read(2'd1, d);
            e = exp_event();
            n_tests++;
            if ((d & EV_MASK) !== e) begin
                n_fail++;
                $display("FAIL rand_drain: got %h need %h", d, e);
            end
        end
    endtask

`ifdef VGA_EVENT_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] e;
        logic [9:0]  base;
        logic [9:0]  w;
        int c1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                // phase the next pair so its first push stamps 1021 and the second wraps to 2
                w = 10'd1018 - base - 10'(cyc);
                idle(int'(w));
            end
            c1 = cyc;
            change(new_val());
            idle(5);
            change(new_val());
            idle(3);
            bus_read(2'd1, d1);
            e = exp_event();
            n_tests++;
            if ((d1 & EV_MASK) !== e) begin
                n_fail++;
                $display("FAIL ts_event1[%0d]: got %h need %h", pass, d1, e);
            end
            bus_read(2'd1, d2);
            e = exp_event();
            n_tests++;
            if ((d2 & EV_MASK) !== e || 10'(d2[31:22] - d1[31:22]) !== 10'd5) begin
                n_fail++;
                $display("FAIL ts_delta[%0d]: got %h and %h need delta 5", pass, d1, d2);
            end
            if (pass == 0) begin
                base = d1[31:22] - 10'(c1 + 3);
            end else begin
                n_tests++;
                if (d1[31:22] !== 10'd1021 || d2[31:22] !== 10'd2) begin
                    n_fail++;
                    $display("FAIL ts_wrap: got %0d,%0d need 1021,2", d1[31:22], d2[31:22]);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(2'd2, 32'h3);
        m_cap   = 1'b1;
        m_irqen = 1'b1;
        for (int i = 0; i < 9; i++) begin
            change(new_val());
            idle(1);
        end
        idle(3);
        bus_read(2'd3, d);
        n_tests++;
        if (d !== exp_status() || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got %h irq %b need %h irq 1", d, irq, exp_status());
        end
        last_in = new_val();
        in_port = last_in;
        reset_n    = 1'b0;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd3;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        reset_n    = 1'b1;
        model_reset();
        n_tests++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: readdata %h irq %b need 0 0", readdata, irq);
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h80) begin
            n_fail++;
            $display("FAIL midreset_status: got %h need 80", d);
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_control: got %h need 0", d);
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_event: got %h need 0", d);
        end
        bus_read(2'd0, d);
        n_tests++;
        if (d !== {10'b0, last_in}) begin
            n_fail++;
            $display("FAIL midreset_data: got %h need %h", d, {10'b0, last_in});
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        in_port    = '0;
        last_in    = '0;
        model_reset();
        idle(1);
        test_reset();
        test_single_event();
        test_overflow();
        test_back_to_back_full_pop();
        test_empty_pop_push();
        test_flush();
        test_disabled();
        test_random();
`ifdef VGA_EVENT_TIMESTAMP_EN
        test_timestamp();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
